// File: rtl/multiple_table_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : multiple_table_gen_if
// Brief    : Request / table-read bundle between the Montgomery datapath
//            and the operand multiple table generator.
// Revision : 1.0
// ============================================================================
interface multiple_table_gen_if #(
  parameter int WIDTH = 1024,
  parameter int K     = 2
);
  logic               start;
  logic [WIDTH-1:0]   operand;
  logic [K-1:0]       rd_sel;
  logic [WIDTH+K-1:0] rd_data;
  logic               busy;
  logic               done;
  logic               table_valid;

  modport master (
    output start, operand, rd_sel,
    input  rd_data, busy, done, table_valid
  );

  modport slave (
    input  start, operand, rd_sel,
    output rd_data, busy, done, table_valid
  );
endinterface
`default_nettype wire

// File: rtl/multiple_table_gen.sv
`default_nettype none
// ============================================================================
// Module   : multiple_table_gen
// Brief    : Builds the table {0*A .. (2^K-1)*A} with shifts for even entries
//            and a chunked ripple adder for odd entries.
// Revision : 1.0
// ============================================================================
module multiple_table_gen #(
  parameter int WIDTH = 1024,
  parameter int K     = 2,
  parameter int ADD_W = 64
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  multiple_table_gen_if.slave bus
);

  localparam int OUT_W = WIDTH + K;
  localparam int DEPTH = 1 << K;
  localparam int NCH   = (OUT_W + ADD_W - 1) / ADD_W;
  localparam int PAD_W = NCH * ADD_W;
  localparam int SUM_W = ADD_W + 1;
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [K-1:0]     c_last_idx   = K'(DEPTH - 1);
  localparam logic [CW-1:0]    c_last_chunk = CW'(NCH - 1);
  localparam logic [PAD_W-1:0] c_chunk_ones = PAD_W'({ADD_W{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_ADD  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [OUT_W-1:0]  r_table [DEPTH];
  logic [WIDTH-1:0]  r_a;
  logic [K-1:0]      r_idx;
  logic [CW-1:0]     r_chunk;
  logic              r_carry;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;

  logic              w_we;
  logic [OUT_W-1:0]  w_wdata;
  logic [K-1:0]      w_prev;
  int unsigned       w_lo;
  logic [SUM_W-1:0]  w_sum;
  logic [OUT_W-1:0]  w_mask;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // The odd-index pass through STEP costs no cycle: an even write heads
  // straight into ADD for the following odd entry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_LOAD;
      S_LOAD: w_next = (K == 1) ? S_FIN : S_STEP;
      S_STEP: w_next = S_ADD;
      S_ADD: begin
        if (r_chunk == c_last_chunk)
          w_next = (r_idx == c_last_idx) ? S_FIN : S_STEP;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_prev = r_idx - K'(1);
    w_lo   = 32'(r_chunk) * ADD_W;
    w_sum  = SUM_W'(ADD_W'(PAD_W'(r_table[w_prev]) >> w_lo))
           + SUM_W'(ADD_W'(PAD_W'(r_a) >> w_lo))
           + SUM_W'(r_carry);
    w_mask = OUT_W'(c_chunk_ones << w_lo);
    w_we    = 1'b0;
    w_wdata = r_table[r_idx >> 1] << 1;
    case (r_state)
      S_STEP: w_we = 1'b1;
      S_ADD: begin
        w_we    = 1'b1;
        w_wdata = (r_table[r_idx] & ~w_mask)
                | OUT_W'(PAD_W'(w_sum[ADD_W-1:0]) << w_lo);
      end
      default: w_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int j = 0; j < DEPTH; j++) r_table[j] <= '0;
    end else if (r_state == S_LOAD) begin
      r_table[0] <= '0;
      r_table[1] <= OUT_W'(r_a);
    end else if (w_we) begin
      r_table[r_idx] <= w_wdata;
    end
  end

  // Status flags are registered, so they trail the state by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a     <= '0;
      r_idx   <= '0;
      r_chunk <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy <= (r_state == S_LOAD) || (r_state == S_STEP) || (r_state == S_ADD);
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.operand;
            r_valid <= 1'b0;
          end
        end
        S_LOAD: r_idx <= K'(2);
        S_STEP: begin
          r_idx   <= r_idx + K'(1);
          r_chunk <= '0;
          r_carry <= 1'b0;
        end
        S_ADD: begin
          r_carry <= w_sum[ADD_W];
          if (r_chunk == c_last_chunk) begin
            r_chunk <= '0;
            r_idx   <= r_idx + K'(1);
          end else begin
            r_chunk <= r_chunk + CW'(1);
          end
        end
        S_FIN:   r_valid <= 1'b1;
        default: r_valid <= r_valid;
      endcase
    end
  end

  assign bus.rd_data     = r_table[bus.rd_sel];
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.table_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_multiple_table_gen.sv
`default_nettype none
// Scoreboard bench: the default configuration plus a K=3/WIDTH=64/ADD_W=16
// instance, with expected tables queued at start and popped after done.
module tb_multiple_table_gen;

  localparam int CHK_W = 1026;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [CHK_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  multiple_table_gen_if #(.WIDTH(1024), .K(2)) d  ();
  multiple_table_gen_if #(.WIDTH(64),   .K(3)) d3 ();

  multiple_table_gen #(.WIDTH(1024), .K(2), .ADD_W(64)) u_def (
    .clk    (clk),
    .resetn (resetn),
    .bus    (d.slave)
  );

  multiple_table_gen #(.WIDTH(64), .K(3), .ADD_W(16)) u_k3 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (d3.slave)
  );

  task automatic check(input string tag, input logic [CHK_W-1:0] got,
                       input logic [CHK_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h",
                  tag, got[CHK_W-1:CHK_W-32], got[127:0],
                  exp[CHK_W-1:CHK_W-32], exp[127:0]);
  endtask

  task automatic start_dut(input bit sel3, input logic [1023:0] a, input bit push);
    int n;
    n = sel3 ? 8 : 4;
    @(negedge clk);
    if (sel3) begin d3.operand = a[63:0]; d3.start = 1'b1; end
    else      begin d.operand  = a;       d.start  = 1'b1; end
    if (push)
      for (int i = 0; i < n; i++)
        exp_q.push_back((sel3 ? CHK_W'(a[63:0]) : CHK_W'(a)) * CHK_W'(i));
    @(posedge clk);
    #1;
    d.start  = 1'b0;
    d3.start = 1'b0;
    check("valid_clr_on_start", CHK_W'(sel3 ? d3.table_valid : d.table_valid), '0);
  endtask

  task automatic wait_dut(input bit sel3, input bit repulse, input string tag);
    int cyc, busy_n, done_n, first, n;
    logic [CHK_W-1:0] exp;
    cyc = 0; busy_n = 0; done_n = 0; first = -1;
    n = sel3 ? 8 : 4;
    while (cyc < 200 && (first < 0 || cyc < first + 3)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sel3 ? d3.busy : d.busy) busy_n++;
      if (sel3 ? d3.done : d.done) begin
        done_n++;
        if (first < 0) first = cyc;
      end
      if (repulse) begin
        if (cyc == 3 || cyc == 10) begin d.operand = 1024'd9; d.start = 1'b1; end
        else d.start = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, CHK_W'(first), CHK_W'(20));
    check({tag, "_busy_cycles"}, CHK_W'(busy_n), CHK_W'(19));
    check({tag, "_done_pulses"}, CHK_W'(done_n), CHK_W'(1));
    check({tag, "_valid"}, CHK_W'(sel3 ? d3.table_valid : d.table_valid), CHK_W'(1));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel3) d3.rd_sel = 3'(i);
      else      d.rd_sel  = 2'(i);
      #1;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check($sformatf("%s_entry%0d", tag, i),
            sel3 ? CHK_W'(d3.rd_data) : CHK_W'(d.rd_data), exp);
    end
  endtask

  initial begin
    d.start = 1'b0;  d.operand  = '0; d.rd_sel  = '0;
    d3.start = 1'b0; d3.operand = '0; d3.rd_sel = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  CHK_W'(d.busy), '0);
    check("rst_done",  CHK_W'(d.done), '0);
    check("rst_valid", CHK_W'(d.table_valid), '0);
    for (int i = 0; i < 4; i++) begin
      d.rd_sel = 2'(i);
      #1;
      check($sformatf("rst_entry%0d", i), CHK_W'(d.rd_data), '0);
    end
    @(negedge clk);
    resetn = 1'b1;

    start_dut(1'b0, 1024'd1, 1'b1);
    wait_dut(1'b0, 1'b0, "a_one");

    start_dut(1'b0, {1024{1'b1}}, 1'b1);
    wait_dut(1'b0, 1'b0, "a_ones");

    start_dut(1'b0, 1024'd0, 1'b1);
    wait_dut(1'b0, 1'b0, "a_zero");
    repeat (5) @(negedge clk);
    check("valid_held_idle", CHK_W'(d.table_valid), CHK_W'(1));

    start_dut(1'b1, 1024'd5, 1'b1);
    wait_dut(1'b1, 1'b0, "k3_a5");

    start_dut(1'b0, 1024'd7, 1'b1);
    wait_dut(1'b0, 1'b1, "restart_ign");

    start_dut(1'b0, 1024'h1234, 1'b0);
    d.rd_sel = 2'd1;
    repeat (8) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("abort_busy",   CHK_W'(d.busy), '0);
    check("abort_done",   CHK_W'(d.done), '0);
    check("abort_valid",  CHK_W'(d.table_valid), '0);
    check("abort_entry1", CHK_W'(d.rd_data), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    start_dut(1'b0, 1024'd4, 1'b1);
    wait_dut(1'b0, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiple_table_gen.md
Name: multiple_table_gen

Overview:
- Precomputes the operand multiple table {0·A, 1·A, …, (2^K−1)·A} for radix-2^K Montgomery multiplication.
- Parametrised successor of the fixed A/2A/3A generator. It is generalised in operand width, radix (table depth) and adder chunk width.
- Even entries come from a 1-bit left shift of entry i/2. Odd entries come from a chunked multi-cycle addition of entry i−1 and A.
- The table is held in an internal register file and read through a random-access port by the Montgomery datapath.

Parameters:
- WIDTH, 1024, operand width in bits.
- K, 2, radix bits. The table holds 2^K entries. Legal range 1..4.
- ADD_W, 64, adder chunk width in bits per cycle. Must be ≥1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request. Ignored while busy=1.
- operand  input  WIDTH  A. Sampled on the edge where start is accepted.
- rd_sel  input  K  table index to read.
- rd_data  output  WIDTH+K  entry rd_sel (= rd_sel·A), combinational from the register file.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when the table is complete.
- table_valid  output  1  high while the table holds a complete result for the last captured A.

Behaviour:
- Definitions:
  - OUT_W = WIDTH+K.
  - NCH = ceil(OUT_W/ADD_W). The internal addition is zero-padded to NCH·ADD_W bits.
  - All table entries are OUT_W bits, zero-extended.
- Reset (resetn=0, asynchronous):
  - busy=0, done=0, table_valid=0.
  - All table entries = 0, so rd_data = 0.
  - FSM returns to IDLE and the captured operand is cleared.
- FSM states and transitions:
  - IDLE: start=1 → capture A, clear table_valid, go to LOAD.
  - LOAD: one cycle. Write entry0=0 and entry1=A. Set i=2. If K=1, go to FIN; otherwise go to STEP.
  - STEP (i even): one cycle. Write entry i = entry(i/2)<<1. Then increment i.
  - STEP (i odd): enter ADD.
  - ADD: NCH cycles.
    - Chunk c (c=0..NCH−1) sums bits [c·ADD_W +: ADD_W] of entry(i−1) and A, plus the carry registered from chunk c−1. Chunk 0 has carry-in 0.
    - The sum chunk is written into entry i.
    - The final carry-out is discarded, since it is always 0 by construction.
    - After chunk NCH−1: increment i, go to STEP.
  - After i = 2^K−1 is written, go to FIN.
  - FIN: one cycle. done=1, table_valid=1. Go to IDLE.
- busy is 1 in LOAD, STEP, ADD and FIN, and 0 in IDLE.
- Latency, with the start edge counted as edge 0:
  - L = 1 + (number of even i in 2..2^K−1) + NCH·(number of odd i in 2..2^K−1).
  - done is high during the cycle after edge L+1.
  - Defaults (K=2, NCH=17): L = 1+1+17 = 19.
  - K=1: L=1.
- start while busy: ignored. There is no restart, and the operand is not re-sampled.
- start in the same cycle as FIN: ignored. It is accepted only from IDLE.
- rd_data reflects the current register contents at all times.
- Data is guaranteed only while table_valid=1. Partially written entries are visible during computation.
- table_valid stays 1 across idle cycles until the next accepted start or reset.
- Reset mid-operation: immediate abort, all outputs go to their reset values, and the next start begins cleanly.
- Arithmetic: every entry equals i·A exactly, with no modular reduction. The maximum value (2^K−1)(2^WIDTH−1) fits in OUT_W bits.

Test Plan:
- Defaults, A=1, start pulse:
  - done at cycle 20 after start.
  - rd_sel 0..3 → 0, 1, 2, 3.
  - busy high for exactly 19 cycles.
- Defaults, A=2^1024−1 (all ones):
  - entry2 = 2^1025−2.
  - entry3 = 3·2^1024−3 = 0x2FF…FFD, 1026 bits. This exercises the carry ripple across all 17 chunks.
- Defaults, A=0:
  - all four entries are 0.
  - table_valid=1 after done.
- K=3, WIDTH=64, ADD_W=16, A=5:
  - NCH=5, L = 1+3+15 = 19.
  - entries are 0, 5, 10, 15, 20, 25, 30, 35.
- Defaults, A=7, then start re-pulsed at cycles 3 and 10 with A=9:
  - the repeated starts are ignored.
  - the result is the table for 7 (21 at entry3), with a single done pulse.
- Defaults, resetn dropped at cycle 8 of computation:
  - outputs are 0 immediately with the asynchronous reset.
  - after release, start with A=4 yields 0, 4, 8, 12 and a normal done.
